// File: rtl/tick_rate_gen_pkg.sv
// Shared types and defaults for the tick/rate generator: FSM state encoding
// and the rate-index to period mapping.
package tick_rate_pkg;

    localparam int DEFAULT_BASE_DIV  = 1000;
    localparam int DEFAULT_SEL_W     = 2;
    localparam int DEFAULT_NUM_RATES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Each rate index halves the period of the previous one.
    function automatic int unsigned period_of(input int unsigned sel,
                                              input int unsigned base_div = DEFAULT_BASE_DIV);
        return base_div >> sel;
    endfunction

endpackage

// File: rtl/tick_rate_gen_if.sv
// Control/status bundle of the tick/rate generator: run enable, rate-change
// handshake and the generated tick, square wave and rate reporting.
interface tick_rate_gen_if #(
    parameter int SEL_W     = 2,
    parameter int NUM_RATES = 4
) ();
    logic                 en;
    logic [SEL_W-1:0]     rate_sel;
    logic                 rate_req;
    logic                 rate_ack;
    logic                 tick;
    logic                 clk_out;
    logic [SEL_W-1:0]     active_rate;
    logic [NUM_RATES-1:0] rate_mult;

    modport master (
        output en, rate_sel, rate_req,
        input  rate_ack, tick, clk_out, active_rate, rate_mult
    );

    modport slave (
        input  en, rate_sel, rate_req,
        output rate_ack, tick, clk_out, active_rate, rate_mult
    );
endinterface

// File: rtl/tick_rate_gen_period_cnt.sv
// Wrap counter 0..period-1 with synchronous clear; `last` flags the final
// count of the current period.
module tick_period_cnt #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W:0]   period,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // period is one bit wider so BASE_DIV itself is representable.
    assign last = ({1'b0, cnt_reg} == (period - (CNT_W+1)'(1)));
    assign cnt  = cnt_reg;

    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (clear || last) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
endmodule

// File: rtl/tick_rate_gen.sv
// Rate-selectable tick and square-wave generator; rate changes are handshaked
// and only take effect on a period boundary (or immediately while idle).
module tick_rate_gen
    import tick_rate_pkg::*;
#(
    parameter int BASE_DIV  = DEFAULT_BASE_DIV,
    parameter int SEL_W     = DEFAULT_SEL_W,
    parameter int NUM_RATES = DEFAULT_NUM_RATES,
    parameter int CNT_W     = $clog2(BASE_DIV)
) (
    input  logic           clk,
    input  logic           rst,
    tick_rate_gen_if.slave bus
);
    state_t               state_reg;
    state_t               state_next;
    logic [SEL_W-1:0]     active_rate_reg;
    logic [SEL_W-1:0]     active_rate_next;
    logic [SEL_W-1:0]     pending_reg;
    logic [SEL_W-1:0]     pending_next;
    logic                 pend_v_reg;
    logic                 pend_v_next;
    logic                 rate_ack_reg;
    logic                 rate_ack_next;

    logic [CNT_W:0]       period;
    logic [CNT_W-1:0]     cnt;
    logic                 last;
    logic                 clear;
    logic                 req_valid;
    logic                 tick;
    logic                 clk_out;
    logic [NUM_RATES-1:0] rate_mult;

    assign period    = (CNT_W+1)'(period_of(32'(active_rate_reg), BASE_DIV));
    assign clear     = (state_reg != RUN) || !bus.en;
    assign req_valid = bus.rate_req && ({1'b0, bus.rate_sel} < (SEL_W+1)'(NUM_RATES));

    tick_period_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .period (period),
        .cnt    (cnt),
        .last   (last)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: run exactly while enable is sampled high
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.en)  state_next = RUN;
            RUN:     if (!bus.en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs, decoded from registered state and count only
    always_comb begin
        tick    = 1'b0;
        clk_out = 1'b0;
        if (state_reg == RUN) begin
            tick    = last;
            clk_out = ({1'b0, cnt} < (period >> 1));
        end
    end

    // Rate handshake. A request arriving on the final count of a period is
    // applied at that same boundary; in IDLE the pending rate applies next edge.
    always_comb begin
        pending_next     = pending_reg;
        pend_v_next      = pend_v_reg;
        active_rate_next = active_rate_reg;
        rate_ack_next    = 1'b0;
        if (req_valid) begin
            pending_next = bus.rate_sel;
            pend_v_next  = 1'b1;
        end
        if (state_reg == IDLE) begin
            if (pend_v_reg) begin
                active_rate_next = pending_reg;
                pend_v_next      = req_valid;
                rate_ack_next    = 1'b1;
            end
        end else if (last && (pend_v_reg || req_valid)) begin
            active_rate_next = req_valid ? bus.rate_sel : pending_reg;
            pend_v_next      = 1'b0;
            rate_ack_next    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_rate_reg <= '0;
            pending_reg     <= '0;
            pend_v_reg      <= 1'b0;
            rate_ack_reg    <= 1'b0;
        end else begin
            active_rate_reg <= active_rate_next;
            pending_reg     <= pending_next;
            pend_v_reg      <= pend_v_next;
            rate_ack_reg    <= rate_ack_next;
        end
    end

    for (genvar gi = 0; gi < NUM_RATES; gi++) begin : g_mult
        assign rate_mult[gi] = (active_rate_reg == SEL_W'(gi));
    end

    assign bus.tick        = tick;
    assign bus.clk_out     = clk_out;
    assign bus.rate_ack    = rate_ack_reg;
    assign bus.active_rate = active_rate_reg;
    assign bus.rate_mult   = rate_mult;
endmodule

// File: tb/tb_tick_rate_gen.sv
// Directed bench for tick_rate_gen with BASE_DIV=16 (periods 16/8/4/2):
// per-cycle checks of tick, clk_out, ack and rate outputs.
module tb_tick_rate_gen;
    localparam int SEL_W     = 2;
    localparam int NUM_RATES = 4;
    localparam int BASE_DIV  = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tick_rate_gen_if #(.SEL_W(SEL_W), .NUM_RATES(NUM_RATES)) bus ();

    tick_rate_gen #(
        .BASE_DIV  (BASE_DIV),
        .SEL_W     (SEL_W),
        .NUM_RATES (NUM_RATES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Expected state: running flag, count, period, active rate, ack strobe.
    bit erun;
    int ecnt;
    int ep;
    int ear;
    bit eack;

    task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cnt=%0d P=%0d)", tag, obs, exp, ecnt, ep);
        end
    endtask

    task automatic chk_all();
        chk1("tick",        32'(bus.tick),        32'(erun && (ecnt == ep - 1)));
        chk1("clk_out",     32'(bus.clk_out),     32'(erun && (ecnt < ep / 2)));
        chk1("rate_ack",    32'(bus.rate_ack),    32'(eack));
        chk1("active_rate", 32'(bus.active_rate), 32'(ear));
        chk1("rate_mult",   32'(bus.rate_mult),   32'(1 << ear));
    endtask

    // One clock edge; model the counter from the inputs that edge samples.
    task automatic adv();
        bit en_s;
        bit rst_s;
        en_s  = bus.en;
        rst_s = rst;
        @(posedge clk);
        #1;
        if (rst_s) begin
            erun = 1'b0;
            ecnt = 0;
            ear  = 0;
            ep   = BASE_DIV;
        end else begin
            ecnt = (erun && en_s) ? ((ecnt == ep - 1) ? 0 : ecnt + 1) : 0;
            erun = en_s;
        end
        eack = 1'b0;
    endtask

    task automatic step_chk(input int n);
        repeat (n) begin
            adv();
            chk_all();
        end
    endtask

    task automatic request(input int sel);
        bus.rate_req = 1'b1;
        bus.rate_sel = SEL_W'(sel);
        $display("req rate_sel=%0d at cnt=%0d P=%0d run=%0d", sel, ecnt, ep, erun);
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.rate_req = 1'b0;
        bus.rate_sel = '0;
        erun = 1'b0; ecnt = 0; ep = BASE_DIV; ear = 0; eack = 1'b0;

        // Reset values
        adv();
        adv();
        chk_all();
        rst = 1'b0;
        $display("reset released");

        // Rate 0: two full 16-cycle periods
        bus.en = 1'b1;
        step_chk(32);

        // Request rate 2 at cnt=5; applies when cnt wraps
        step_chk(6);
        request(2);
        adv(); bus.rate_req = 1'b0; chk_all();
        step_chk(9);
        adv(); eack = 1'b1; ear = 2; ep = 4; chk_all();
        $display("ack rate=2");
        step_chk(8);

        // Request on the final count applies at that same edge
        step_chk(3);
        request(0);
        adv(); bus.rate_req = 1'b0; eack = 1'b1; ear = 0; ep = 16; chk_all();
        $display("ack rate=0");

        // Two requests in one period: last wins, single ack
        step_chk(3);
        request(1);
        adv(); bus.rate_req = 1'b0; chk_all();
        step_chk(5);
        request(3);
        adv(); bus.rate_req = 1'b0; chk_all();
        step_chk(5);
        adv(); eack = 1'b1; ear = 3; ep = 2; chk_all();
        $display("ack rate=3");
        step_chk(4);

        // Request equal to the active rate is still acknowledged
        request(3);
        adv(); bus.rate_req = 1'b0; chk_all();
        adv(); eack = 1'b1; chk_all();
        $display("ack rate=3 (same)");
        adv(); chk_all();
        request(0);
        adv(); bus.rate_req = 1'b0; eack = 1'b1; ear = 0; ep = 16; chk_all();
        $display("ack rate=0");

        // Drop enable at cnt=10: no partial tick; re-enable gives a full period
        step_chk(10);
        bus.en = 1'b0;
        $display("en low at cnt=%0d", ecnt);
        step_chk(4);
        bus.en = 1'b1;
        step_chk(16);

        // IDLE request: ack two edges later, next run uses P=8
        bus.en = 1'b0;
        step_chk(2);
        request(1);
        adv(); bus.rate_req = 1'b0; chk_all();
        adv(); eack = 1'b1; ear = 1; ep = 8; chk_all();
        $display("ack rate=1 (idle)");
        step_chk(2);
        bus.en = 1'b1;
        step_chk(19);

        // Enable dropped with the request: pending applies on the next edge
        request(2);
        bus.en = 1'b0;
        adv(); bus.rate_req = 1'b0; chk_all();
        adv(); eack = 1'b1; ear = 2; ep = 4; chk_all();
        $display("ack rate=2 (after en drop)");

        // Reset with a request pending: discarded, no ack
        bus.en = 1'b1;
        step_chk(1);
        request(3);
        adv(); bus.rate_req = 1'b0; chk_all();
        rst    = 1'b1;
        bus.en = 1'b0;
        adv(); chk_all();
        rst = 1'b0;
        $display("reset with pending request");
        step_chk(3);
        bus.en = 1'b1;
        step_chk(17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tick_rate_gen.md
# tick_rate_gen

Parametrised, synthesizable successor to the washing-machine controller's behavioural frequency decoder. It derives a one-cycle `tick` strobe and a square-wave `clk_out` from the single system clock, selectable among `NUM_RATES` binary-multiple rates. Rate changes use a request/acknowledge handshake and take effect only on a period boundary, so the timer FSM downstream never sees a truncated period. It also reports the active rate multiplier.

## Interface
- `BASE_DIV`, 1000: `clk` cycles per period at rate 0; must satisfy `BASE_DIV >> (NUM_RATES-1) >= 2`.
- `SEL_W`, 2: width of the rate select.
- `NUM_RATES`, 4: number of selectable rates, `<= 2**SEL_W`.
- `CNT_W`, `$clog2(BASE_DIV)`: width of the period counter.
---
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous reset, active-high.
- `en`  in  1: run enable, level.
- `rate_sel`  in  `SEL_W`: requested rate index, sampled only when `rate_req=1`.
- `rate_req`  in  1: one-cycle rate-change request.
- `rate_ack`  out  1: one-cycle pulse in the first cycle the new rate is active.
- `tick`  out  1: one-cycle strobe on the last cycle of each period.
- `clk_out`  out  1: square wave with the same period as `tick`.
- `active_rate`  out  `SEL_W`: rate index currently in force.
- `rate_mult`  out  `NUM_RATES`: `1 << active_rate` (multiples 1, 2, 4, 8 for the defaults).

## Operation
- Period: `P = BASE_DIV >> active_rate`. Counter `cnt` runs 0..P-1 and wraps to 0.
- FSM, two states:
  - IDLE: `cnt=0`, `tick=0`, `clk_out=0`.
  - RUN: counting.
  - IDLE→RUN on an edge that samples `en=1`.
  - RUN→IDLE on an edge that samples `en=0`. `cnt` clears; no partial-period tick is produced.
- Outputs are Moore decodes of registered state:
  - `tick = RUN && cnt==P-1`
  - `clk_out = RUN && cnt < P/2`
  - `clk_out` is high for the first `P/2` cycles and low for the remaining `P - P/2`.
- Rate request: at an edge sampling `rate_req=1` with `rate_sel < NUM_RATES`, `rate_sel` is latched into `pending` and `pend_v` is set.
  - If `rate_sel >= NUM_RATES`, the request is dropped: no pending entry, no ack.
- Apply point:
  - In IDLE, a valid pending rate applies at the next edge.
  - In RUN, it applies at the edge where `cnt==P-1`; the new P takes effect from `cnt=0`.
  - `rate_ack` is high for exactly the one cycle after the apply edge.
- Boundary cases:
  - A new request while `pend_v` is set overwrites `pending` (last wins). One ack only.
  - A request sampled in the same cycle as `cnt==P-1` applies at that same edge.
  - A request equal to `active_rate` is still acknowledged.
  - `en` falling while `pend_v` is set: the pending rate is kept and applies on the next edge (IDLE rule).
  - `rst` mid-operation: `pending` is discarded and no ack is issued.
- Reset values:
  - state IDLE, `cnt=0`, `active_rate=0`, `pend_v=0`
  - `tick=0`, `clk_out=0`, `rate_ack=0`, `rate_mult=1`

## Timing
- `en` sampled high at edge t → RUN with `cnt=0` during cycle t+1. First `tick` falls in cycle t+P.
- `tick` then repeats every P cycles.
- Request-to-ack latency:
  - IDLE: 2 edges (latch, then apply).
  - RUN: from 1 edge up to P edges.
- `active_rate` and `rate_mult` change on the apply edge, i.e. the same cycle `rate_ack` goes high.
- No combinational path from any input to any output.

## Structure
- Package `tick_rate_pkg` holds:
  - the state enum `{IDLE, RUN}`
  - the function `period_of(sel)` returning `BASE_DIV >> sel`
  - defaults for `BASE_DIV`, `SEL_W` and `NUM_RATES`
- One natural sub-module: `tick_period_cnt`, a loadable wrap counter with `clear` and period inputs and a `last` output. The FSM and handshake stay in the top module.

## Test plan
Run with `BASE_DIV=16`, `NUM_RATES=4`, so P = 16 / 8 / 4 / 2.
- Reset, then `en=1` at rate 0 → first `tick` 16 cycles after `en` is sampled, then every 16 cycles. `clk_out` is 8 cycles high, 8 low. `rate_mult=1`.
- In RUN at rate 0, pulse `rate_req` with `rate_sel=2` at `cnt=5` → the rest of the 16-cycle period completes. `rate_ack`, `active_rate=2` and `rate_mult=4` all appear in the cycle `cnt` returns to 0. Ticks then come every 4 cycles.
- `rate_req` with `rate_sel=1` at `cnt=3`, then with `rate_sel=3` at `cnt=9` (P=16) → a single ack; `active_rate=3`; P=2 afterwards.
- `en` dropped at `cnt=10` → next cycle `cnt=0`, `clk_out=0`, no tick. Re-enable → a full period before the next tick.
- In IDLE, `rate_req` with `rate_sel=1` → ack 2 edges later. The following RUN uses P=8.
- `rst` asserted while a request is pending → all reset values restored, no ack, `active_rate=0`.
